// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF evaluation sequencer.
// Holds the FSM state encoding, the RO pair derivation and the default counter width.
package puf_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  // Returns {sel_a, sel_b} for measurement k; an RO is never compared with itself.
  function automatic logic [5:0] pair_sel(input logic [2:0] base_a,
                                          input logic [2:0] base_b,
                                          input logic [2:0] k);
    logic [2:0] a;
    logic [2:0] b;
    a = base_a + k;
    b = base_b + k;
    if (a == b) b = a ^ 3'b100;
    return {a, b};
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Down-counting window timer: load arms it for load_val cycles; expire is high on the last one.
// A load in the expire cycle re-arms it back-to-back, so consecutive windows need no gap.
module puf_window_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] cnt;
  logic          active;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val - TW'(1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - TW'(1);
    end
  end

  assign expire = active && (cnt == '0);

endmodule

// File: rtl/puf_eval_sequencer.sv
// RO-PUF sequencer: one challenge in, RESP_BITS response bits out via CLEAR/MEASURE/SETTLE/COMPARE per bit.
// Define PUF_MAJORITY_VOTE_EN to measure each bit three times and keep the majority result.
module puf_eval_sequencer
  import puf_pkg::*;
#(
  parameter int RESP_BITS     = 8,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WIN_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           challenge,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic                 ro_en,
  output logic                 cnt_rst,
  output logic [2:0]           sel_a,
  output logic [2:0]           sel_b,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [3:0]           tie_cnt
);

  localparam int TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WIN_LD    = TW'(WIN_CYCLES);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES);

  state_t        state, state_n;
  logic [5:0]    ch_q;
  logic [2:0]    k;
  logic          last_bit, last_meas, meas_bit, meas_tie;
  logic          tmr_load, tmr_expire;
  logic [TW-1:0] tmr_val;
  logic          unused_ch;

  assign unused_ch = ^challenge[7:6];
  assign last_bit  = (k == 3'(RESP_BITS - 1));
  assign meas_bit  = (count_a > count_b);
  assign meas_tie  = (count_a == count_b);

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] vote_idx, ones;
  logic       maj;
  assign last_meas = (vote_idx == 2'd2);
  assign maj       = (ones == 2'd2) || ((ones == 2'd1) && meas_bit);
`else
  assign last_meas = 1'b1;
`endif

  puf_window_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = WIN_LD;
    case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR: begin
        state_n  = MEASURE;
        tmr_load = 1'b1;
      end
      MEASURE: if (tmr_expire) begin
        state_n  = SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LD;
      end
      SETTLE:  if (tmr_expire) state_n = COMPARE;
      COMPARE: state_n = (last_meas && last_bit) ? DONE : CLEAR;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      ro_en    <= 1'b0;
      cnt_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_a    <= '0;
      sel_b    <= '0;
      response <= '0;
      tie_cnt  <= '0;
      ch_q     <= '0;
      k        <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_idx <= '0;
      ones     <= '0;
`endif
    end else begin
      ro_en   <= (state_n == MEASURE);
      cnt_rst <= (state_n inside {IDLE, CLEAR, DONE});
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      if (state == IDLE && start) begin
        ch_q           <= challenge[5:0];
        {sel_a, sel_b} <= pair_sel(challenge[2:0], challenge[5:3], 3'd0);
        k              <= '0;
        response       <= '0;
        tie_cnt        <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
        vote_idx       <= '0;
        ones           <= '0;
`endif
      end
      if (state == COMPARE) begin
        if (meas_tie && tie_cnt != 4'd15) tie_cnt <= tie_cnt + 4'd1;
`ifdef PUF_MAJORITY_VOTE_EN
        if (!last_meas) begin
          vote_idx <= vote_idx + 2'd1;
          ones     <= ones + {1'b0, meas_bit};
        end else begin
          vote_idx <= '0;
          ones     <= '0;
          response <= response | (RESP_BITS'(maj) << k);
        end
`else
        response <= response | (RESP_BITS'(meas_bit) << k);
`endif
        if (last_meas && !last_bit) begin
          k              <= k + 3'd1;
          {sel_a, sel_b} <= pair_sel(ch_q[2:0], ch_q[5:3], k + 3'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Bench for puf_eval_sequencer: behavioural RO counters, table-driven and random evaluations vs a count-level model.
module tb_puf_eval_sequencer;

  localparam int R = 8;
  localparam int W = 16;
  localparam int S = 4;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int MPB = 3;
`else
  localparam int MPB = 1;
`endif
  localparam int NMEAS   = R * MPB;
  localparam int EXP_LAT = 1 + NMEAS * (1 + W + S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] challenge;
  logic [7:0] count_a = 8'd0, count_b = 8'd0;
  logic       ro_en, cnt_rst, busy, done;
  logic [2:0] sel_a, sel_b;
  logic [7:0] response;
  logic [3:0] tie_cnt;

  int tests = 0, fails = 0;

  puf_eval_sequencer #(.RESP_BITS(R), .CNT_W(8), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .count_a(count_a), .count_b(count_b), .ro_en(ro_en), .cnt_rst(cnt_rst),
    .sel_a(sel_a), .sel_b(sel_b), .busy(busy), .done(done),
    .response(response), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ring-oscillator counter model: per-measurement edge rates, counting only while ro_en is high.
  int   ra_m[NMEAS], rb_m[NMEAS];
  int   mi = 0;
  logic en_seen = 1'b0, model_clr = 1'b0;
  logic [7:0] cur_ch = 8'h00;

  always @(posedge clk) begin
    if (model_clr) begin
      mi      <= 0;
      en_seen <= 1'b0;
    end else if (ro_en) en_seen <= 1'b1;
    else if (en_seen) begin
      en_seen <= 1'b0;
      mi      <= mi + 1;
    end
    if (cnt_rst) begin
      count_a <= 8'd0;
      count_b <= 8'd0;
    end else if (ro_en && mi < NMEAS) begin
      count_a <= count_a + 8'(ra_m[mi]);
      count_b <= count_b + 8'(rb_m[mi]);
    end
  end

  function automatic int exp_sel_a(input int ch, input int k);
    return ((ch & 7) + k) % 8;
  endfunction

  function automatic int exp_sel_b(input int ch, input int k);
    int a, b;
    a = ((ch & 7) + k) % 8;
    b = (((ch >> 3) & 7) + k) % 8;
    if (a == b) b = a ^ 4;
    return b;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // Expected response/ties from the per-measurement rates: counts are rate*W modulo 2^CNT_W.
  function automatic void model(output logic [7:0] resp, output int ties);
    int ca, cb, votes;
    resp = 8'h00;
    ties = 0;
    for (int b = 0; b < R; b++) begin
      votes = 0;
      for (int m = 0; m < MPB; m++) begin
        ca = (ra_m[b*MPB+m] * W) % 256;
        cb = (rb_m[b*MPB+m] * W) % 256;
        if (ca > cb) votes++;
        if (ca == cb) ties++;
      end
      resp[b] = (2 * votes > MPB);
    end
    ties = sat15(ties);
  endfunction

  // Pair check at the first cycle of every measurement window.
  logic ro_prev_n = 1'b0;
  always @(negedge clk) begin
    if (ro_en && !ro_prev_n && !rst) begin
      check("sel_a", 32'(sel_a), 32'(exp_sel_a(int'(cur_ch), mi / MPB)));
      check("sel_b", 32'(sel_b), 32'(exp_sel_b(int'(cur_ch), mi / MPB)));
      check("sel_distinct", 32'(sel_a != sel_b), 32'd1);
      check("cnt_rst_in_window", 32'(cnt_rst), 32'd0);
    end
    ro_prev_n <= ro_en;
  end

  task automatic run_eval(input logic [7:0] ch, input logic [7:0] exp_resp, input int exp_tie, input string tag);
    int n;
    @(negedge clk);
    cur_ch    = ch;
    challenge = ch;
    model_clr = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    n = 1;
    @(negedge clk);
    start     = 1'b0;
    model_clr = 1'b0;
    challenge = ~ch;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n + 1), 32'(EXP_LAT));
    check({tag, "_response"}, 32'(response), 32'(exp_resp));
    check({tag, "_tie_cnt"}, 32'(tie_cnt), 32'(exp_tie));
    check({tag, "_windows"}, 32'(mi), 32'(NMEAS));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 check({tag, "_resp_hold"}, 32'(response), 32'(exp_resp));
  endtask

  typedef struct {
    logic [7:0]      ch;
    logic [7:0][3:0] ra;
    logic [7:0][3:0] rb;
    logic [7:0]      exp_resp;
    int              exp_tie;
  } vec_t;

  vec_t vecs[4];
  int   ndone, tie_m;
  logic seen_en;
  logic [7:0] resp_m;

  initial begin
    vecs[0] = '{8'h10, 32'h39393939, 32'h75757575, 8'h55, 0};
    vecs[1] = '{8'h00, 32'h12345678, 32'h87654321, 8'h0F, 0};
    vecs[2] = '{8'h00, 32'h66666666, 32'h66666666, 8'h00, 8};
    vecs[3] = '{8'hFF, 32'h5A5A5A5A, 32'h5555AAAA, 8'h50, 4};

    // Reset, with start held during reset
    rst = 1'b1; start = 1'b1; challenge = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("rst_ro_en", 32'(ro_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_response", 32'(response), 32'd0);
    check("rst_tie_cnt", 32'(tie_cnt), 32'd0);
    check("rst_sels", 32'({sel_a, sel_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("start_in_rst_ignored", 32'(busy), 32'd0);

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < NMEAS; m++) begin
        ra_m[m] = int'(vecs[i].ra[m / MPB]);
        rb_m[m] = int'(vecs[i].rb[m / MPB]);
      end
      run_eval(vecs[i].ch, vecs[i].exp_resp, sat15(vecs[i].exp_tie * MPB), $sformatf("vec%0d", i));
    end

    // Randomised evaluations
    for (int it = 0; it < 6; it++) begin
      for (int m = 0; m < NMEAS; m++) begin
        ra_m[m] = int'($urandom_range(15, 0));
        rb_m[m] = ($urandom_range(3, 0) == 0) ? ra_m[m] : int'($urandom_range(15, 0));
      end
      model(resp_m, tie_m);
      run_eval(8'($urandom), resp_m, tie_m, $sformatf("rand%0d", it));
    end

`ifdef PUF_MAJORITY_VOTE_EN
    // Bit 0 sees results 1,0,1; every other measurement ties
    for (int m = 0; m < NMEAS; m++) begin ra_m[m] = 3; rb_m[m] = 3; end
    ra_m[0] = 9; rb_m[0] = 5;
    ra_m[1] = 2; rb_m[1] = 8;
    ra_m[2] = 9; rb_m[2] = 5;
    run_eval(8'h21, 8'h01, 15, "vote101");
`endif

    // Start held high for a whole evaluation gives exactly one done
    for (int m = 0; m < NMEAS; m++) begin ra_m[m] = 4; rb_m[m] = 2; end
    @(negedge clk);
    cur_ch = 8'h10; challenge = 8'h10; model_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3000 && ndone == 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        start = 1'b0;
      end
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_start_one_done", 32'(ndone), 32'd1);
    check("held_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of a measurement window
    @(negedge clk);
    cur_ch = 8'h2C; challenge = 8'h2C; model_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; model_clr = 1'b0;
    seen_en = 1'b0;
    for (int c = 0; c < 50 && !seen_en; c++) begin
      @(negedge clk);
      if (ro_en) seen_en = 1'b1;
    end
    check("mid_rst_window_open", 32'(seen_en), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ro_en", 32'(ro_en), 32'd0);
    check("mid_rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_response", 32'(response), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    check("mid_rst_stays_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
